key_event_gen: RTL and testbench

KEY_EVENT_GEN -- requirements
Module: key_event_gen

---
 rtl/key_event_pkg.sv | 21 ++
 rtl/key_fsm.sv | 96 +++++++++
 rtl/key_event_gen.sv | 81 ++++++++
 tb/tb_key_event_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: event/state encodings and counter sizing shared by key_event_gen (KEY_EVENT_REPEAT_EN enables REPEAT)
package key_event_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_LONG    = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } event_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/key_fsm.sv
// key_fsm: per-key edge detector, IDLE/DOWN/HELD FSM, hold counter and one-entry pending slot (REPEAT under KEY_EVENT_REPEAT_EN)
module key_fsm
    import key_event_pkg::*;
#(
    parameter int LongCycles   = 50000,
    parameter int RepeatCycles = 10000
) (
    input  logic   Clk,
    input  logic   nRst,
    input  logic   Button,
    input  logic   Drain,
    output logic   PendValid,
    output event_t PendType,
    output logic   Dropped
);

    localparam int CntW = cnt_width(LongCycles, RepeatCycles);

    state_t            state, state_nx;
    logic [CntW-1:0]   cnt, cnt_nx;
    logic              btn_q, fire;
    event_t            ev;
    logic              press_edge, rel_edge;

    assign press_edge = btn_q & ~Button;
    assign rel_edge   = ~btn_q & Button;
    assign Dropped    = fire & PendValid & ~Drain;

    // Next state, counter and raised event; a release edge wins over a maturing LONG/REPEAT
    always_comb begin
        state_nx = state;
        cnt_nx   = (&cnt) ? cnt : cnt + 1'b1;
        fire     = 1'b0;
        ev       = EV_PRESS;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (press_edge) begin
                    state_nx = ST_DOWN;
                    fire     = 1'b1;
                end
            end
            ST_DOWN: begin
                if (rel_edge) begin
                    state_nx = ST_IDLE;
                    fire     = 1'b1;
                    ev       = EV_RELEASE;
                end else if (cnt == CntW'(LongCycles - 1)) begin
                    state_nx = ST_HELD;
                    cnt_nx   = '0;
                    fire     = 1'b1;
                    ev       = EV_LONG;
                end
            end
            ST_HELD: begin
                if (rel_edge) begin
                    state_nx = ST_IDLE;
                    fire     = 1'b1;
                    ev       = EV_RELEASE;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (cnt == CntW'(RepeatCycles - 1)) begin
                    cnt_nx = '0;
                    fire   = 1'b1;
                    ev     = EV_REPEAT;
                end
`else
                cnt_nx = '0;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counter, edge register (reset to unpressed) and pending slot
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            btn_q     <= 1'b1;
            PendValid <= 1'b0;
            PendType  <= EV_PRESS;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            btn_q <= Button;
            if (fire && (!PendValid || Drain)) begin
                PendValid <= 1'b1;
                PendType  <= ev;
            end else if (Drain) begin
                PendValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: turns debounced active-low keys into PRESS/LONG/REPEAT/RELEASE events on a valid/ready port (REPEAT needs KEY_EVENT_REPEAT_EN)
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int ClockFrequency = 50000000,
    parameter int NumKeys        = 4,
    parameter int LongPressMs    = 1000,
    parameter int RepeatMs       = 200
) (
    input  logic               Clk,
    input  logic               nRst,
    input  logic [NumKeys-1:0] ButtonIn,
    output logic               EventValid,
    input  logic               EventReady,
    output logic [3:0]         EventKey,
    output logic [1:0]         EventType,
    output logic               EventDropped
);

    localparam int LongCycles   = (ClockFrequency / 1000) * LongPressMs;
    localparam int RepeatCycles = (ClockFrequency / 1000) * RepeatMs;

    logic [NumKeys-1:0] pend_valid, drain, dropped;
    event_t             pend_type [NumKeys];
    logic [3:0]         sel;
    event_t             sel_type;
    logic               load;

    assign load = ~EventValid | EventReady;

    for (genvar k = 0; k < NumKeys; k++) begin : gen_key
        key_fsm #(
            .LongCycles  (LongCycles),
            .RepeatCycles(RepeatCycles)
        ) u_key (
            .Clk      (Clk),
            .nRst     (nRst),
            .Button   (ButtonIn[k]),
            .Drain    (drain[k]),
            .PendValid(pend_valid[k]),
            .PendType (pend_type[k]),
            .Dropped  (dropped[k])
        );
    end

    // Fixed-priority pick of the lowest pending key, drained only when the output can load
    always_comb begin
        sel      = '0;
        sel_type = EV_PRESS;
        drain    = '0;
        for (int i = NumKeys - 1; i >= 0; i--) begin
            if (pend_valid[i]) begin
                sel      = 4'(i);
                sel_type = pend_type[i];
            end
        end
        for (int i = 0; i < NumKeys; i++) begin
            drain[i] = load & pend_valid[i] & (sel == 4'(i));
        end
    end

    // Output register holds steady under backpressure; dropped flag is sticky until reset
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            EventValid   <= 1'b0;
            EventKey     <= '0;
            EventType    <= '0;
            EventDropped <= 1'b0;
        end else begin
            if (load) begin
                EventValid <= |pend_valid;
                if (|pend_valid) begin
                    EventKey  <= sel;
                    EventType <= sel_type;
                end
            end
            EventDropped <= EventDropped | (|dropped);
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed scenarios with a cycle-stamped scoreboard of expected events
module tb_key_event_gen;
    import key_event_pkg::*;

    typedef struct {
        logic [3:0] key;
        logic [1:0] typ;
        int         cyc;
    } exp_t;

    logic       Clk, nRst, EventValid, EventReady, EventDropped;
    logic [3:0] ButtonIn, EventKey;
    logic [1:0] EventType;
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    exp_t       sb [$];
    exp_t       mon_e;

    key_event_gen #(
        .ClockFrequency(1000),
        .NumKeys       (4),
        .LongPressMs   (5),
        .RepeatMs      (2)
    ) dut (
        .Clk         (Clk),
        .nRst        (nRst),
        .ButtonIn    (ButtonIn),
        .EventValid  (EventValid),
        .EventReady  (EventReady),
        .EventKey    (EventKey),
        .EventType   (EventType),
        .EventDropped(EventDropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push(input int k, input int t, input int c);
        sb.push_back('{key: 4'(k), typ: 2'(t), cyc: c});
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || EventValid) && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        step(3);
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_drain: observed %0d outstanding events, expected 0", tag, sb.size());
        end
    endtask

    // Every accepted transfer is popped from the scoreboard and checked for key, type and cycle
    always @(negedge Clk) begin
        if (nRst && EventValid && EventReady) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed key %0d type %0d, expected none", EventKey, EventType);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_assert += 2;
                assert ({EventKey, EventType} === {mon_e.key, mon_e.typ}) else begin
                    n_fail++;
                    $error("FAIL event_id: observed key %0d type %0d, expected key %0d type %0d", EventKey, EventType, mon_e.key, mon_e.typ);
                end
                assert (cyc === mon_e.cyc) else begin
                    n_fail++;
                    $error("FAIL event_cycle: observed cycle %0d, expected cycle %0d (key %0d type %0d)", cyc, mon_e.cyc, mon_e.key, mon_e.typ);
                end
            end
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRst       = 1'b0;
        ButtonIn   = 4'hF;
        EventReady = 1'b1;
        step(3);
        chk("rst_valid", 8'(EventValid), 8'd0);
        chk("rst_key", 8'(EventKey), 8'd0);
        chk("rst_type", 8'(EventType), 8'd0);
        chk("rst_dropped", 8'(EventDropped), 8'd0);
        nRst = 1'b1;
        step(2);

        // single short press of key 2
        ButtonIn[2] = 1'b0;
        push(2, EV_PRESS, cyc + 2);
        step(3);
        ButtonIn[2] = 1'b1;
        push(2, EV_RELEASE, cyc + 2);
        wait_drain("single");
        chk("single_dropped", 8'(EventDropped), 8'd0);

        // long hold of key 0
        ButtonIn[0] = 1'b0;
        push(0, EV_PRESS, cyc + 2);
        push(0, EV_LONG, cyc + 7);
`ifdef KEY_EVENT_REPEAT_EN
        push(0, EV_REPEAT, cyc + 9);
        push(0, EV_REPEAT, cyc + 11);
`endif
        step(10);
        ButtonIn[0] = 1'b1;
        push(0, EV_RELEASE, cyc + 2);
        wait_drain("long");
        chk("long_dropped", 8'(EventDropped), 8'd0);

        // keys 3 and 1 pressed and released together
        ButtonIn[3] = 1'b0;
        ButtonIn[1] = 1'b0;
        push(1, EV_PRESS, cyc + 2);
        push(3, EV_PRESS, cyc + 3);
        step(4);
        ButtonIn[3] = 1'b1;
        ButtonIn[1] = 1'b1;
        push(1, EV_RELEASE, cyc + 2);
        push(3, EV_RELEASE, cyc + 3);
        wait_drain("simul");
        chk("simul_dropped", 8'(EventDropped), 8'd0);

        // release in the very cycle LONG would mature
        ButtonIn[2] = 1'b0;
        push(2, EV_PRESS, cyc + 2);
        step(5);
        ButtonIn[2] = 1'b1;
        push(2, EV_RELEASE, cyc + 2);
        wait_drain("race");
        chk("race_dropped", 8'(EventDropped), 8'd0);

        // backpressure: PRESS held in the output, LONG parks in the slot, later events dropped
        EventReady  = 1'b0;
        ButtonIn[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i >= 2) chk("bp_stable", {1'b0, EventValid, EventKey, EventType}, {1'b0, 1'b1, 4'd0, 2'd0});
            @(posedge Clk);
            #1;
            if (i == 9) ButtonIn[0] = 1'b1;
        end
        EventReady = 1'b1;
        push(0, EV_PRESS, cyc);
        push(0, EV_LONG, cyc + 1);
        wait_drain("bp");
        chk("bp_dropped", 8'(EventDropped), 8'd1);

        // reset while key 0 is in HELD
        ButtonIn[0] = 1'b0;
        push(0, EV_PRESS, cyc + 2);
        push(0, EV_LONG, cyc + 7);
        step(8);
        nRst = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(EventValid), 8'd0);
        chk("mid_rst_key", 8'(EventKey), 8'd0);
        chk("mid_rst_type", 8'(EventType), 8'd0);
        chk("mid_rst_dropped", 8'(EventDropped), 8'd0);
        chk("mid_rst_sb", 8'(sb.size()), 8'd0);
        step(2);
        chk("mid_rst_valid2", 8'(EventValid), 8'd0);
        nRst = 1'b1;
        push(0, EV_PRESS, cyc + 2);
        step(3);
        ButtonIn[0] = 1'b1;
        push(0, EV_RELEASE, cyc + 2);
        wait_drain("reset");
        chk("post_rst_dropped", 8'(EventDropped), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
